// File: rtl/context_update.sv
// context_update: JPEG-LS per-context A/B/C/N read-modify-write stage with
// 365-entry store, N-halving at 64, bias-cancellation update and R->U hazard bypass.
module context_update #(
  parameter int N_length   = 7,
  parameter int A_length   = 16,
  parameter int B_length   = 8,
  parameter int C_length   = 8,
  parameter int ERR_length = 8,
  parameter int CTX_COUNT  = 365,
  parameter int A_INIT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8:0]            in_q,
  input  logic [ERR_length-1:0] in_err,
  output logic                  out_valid,
  output logic [8:0]            out_q,
  output logic [A_length-1:0]   out_a,
  output logic [B_length-1:0]   out_b,
  output logic [C_length-1:0]   out_c,
  output logic [N_length-1:0]   out_n,
  output logic                  out_reset
);
  localparam int BW = B_length + 2;
  localparam int W = A_length + B_length + C_length + N_length;
  localparam logic signed [C_length-1:0] C_MIN = {1'b1, {(C_length-1){1'b0}}};
  localparam logic signed [C_length-1:0] C_MAX = ~C_MIN;
  typedef enum logic {INIT, RUN} state_t;
  state_t st;
  logic [8:0] cnt;
  // Full 9-bit address space so an illegal q never aliases a real context
  logic [W-1:0] mem [512];
  logic r_valid, u_valid;
  logic [8:0] r_q, u_q;
  logic signed [ERR_length-1:0] r_err, u_err;
  logic [A_length-1:0] u_a, asum, a1;
  logic signed [B_length-1:0] u_b, bf;
  logic signed [C_length-1:0] u_c, cf;
  logic [N_length-1:0] u_n, n1;
  logic [ERR_length-1:0] mag;
  logic signed [BW-1:0] bsum, b1, nn, b_lo, b_hi;
  logic half, neg, pos, hi_pos, byp, we;
  logic [W-1:0] upd, rd, wd;
  logic [8:0] wa;
  assign mag = u_err[ERR_length-1] ? -u_err : u_err;
  assign asum = u_a + A_length'(mag);
  assign bsum = BW'(u_b) + BW'(u_err);
  assign half = u_n == N_length'(64);
  assign a1 = half ? asum >> 1 : asum;
  assign b1 = half ? bsum >>> 1 : bsum;
  assign n1 = half ? N_length'(33) : u_n + N_length'(1);
  assign nn = $signed({{(BW-N_length){1'b0}}, n1});
  assign b_lo = b1 + nn;
  assign b_hi = b1 - nn;
  assign neg = b1 <= -nn;
  assign pos = !b1[BW-1] && (|b1);
  assign hi_pos = !b_hi[BW-1] && (|b_hi);
  assign bf = B_length'(neg ? (b_lo <= -nn ? BW'(1) - nn : b_lo) : pos ? (hi_pos ? '0 : b_hi) : b1);
  assign cf = neg ? (u_c != C_MIN ? u_c - C_length'(1) : u_c) :
              pos ? (u_c != C_MAX ? u_c + C_length'(1) : u_c) : u_c;
  assign upd = {a1, bf, cf, n1};
  assign rd = mem[r_q];
  assign byp = r_valid && u_valid && r_q == u_q;
  assign we = rst_n && !restart && (st == INIT || u_valid);
  assign wa = st == INIT ? cnt : u_q;
  assign wd = st == INIT ? {A_length'(A_INIT), {(B_length+C_length){1'b0}}, N_length'(1)} : upd;
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      st <= INIT;
      cnt <= '0;
      in_ready <= 1'b0;
      r_valid <= 1'b0;
      u_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (st == INIT) begin
        cnt <= cnt + 9'd1;
        if (cnt == 9'(CTX_COUNT-1)) begin
          st <= RUN;
          in_ready <= 1'b1;
        end
      end
      r_valid <= in_valid && in_ready;
      u_valid <= r_valid;
      out_valid <= u_valid;
    end
    r_q <= in_q;
    r_err <= in_err;
    u_q <= r_q;
    u_err <= r_err;
    {u_a, u_b, u_c, u_n} <= byp ? upd : rd;
    if (!rst_n) begin
      out_q <= '0;
      out_a <= '0;
      out_b <= '0;
      out_c <= '0;
      out_n <= '0;
      out_reset <= 1'b0;
    end else if (u_valid && !restart) begin
      out_q <= u_q;
      out_a <= a1;
      out_b <= bf;
      out_c <= cf;
      out_n <= n1;
      out_reset <= half;
    end
  end
endmodule
